// File: rtl/cic_decim_ctrl_if.sv
// Control/handshake bundle between the sample source, the CIC controller and
// the integrator/comb datapath instances.
interface cic_decim_ctrl_if #(
    parameter int RATE_W = 8
);
    logic [RATE_W-1:0] cfg_rate_i;
    logic              start_i;
    logic              stop_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              int_en_o;
    logic              int_clr_o;
    logic              comb_en_o;
    logic              comb_clr_o;
    logic              out_valid_o;
    logic              busy_o;
    logic [1:0]        state_o;
    logic [RATE_W-1:0] phase_o;

    modport slave (
        input  cfg_rate_i, start_i, stop_i, in_valid_i,
        output in_ready_o, int_en_o, int_clr_o, comb_en_o, comb_clr_o,
               out_valid_o, busy_o, state_o, phase_o
    );

    modport master (
        output cfg_rate_i, start_i, stop_i, in_valid_i,
        input  in_ready_o, int_en_o, int_clr_o, comb_en_o, comb_clr_o,
               out_valid_o, busy_o, state_o, phase_o
    );
endinterface

// File: rtl/cic_decim_ctrl.sv
// Sequencer for a single-stage CIC decimator: gates the integrator per accepted
// sample, strobes the comb every R accepts, masks comb warm-up and drains on stop.
module cic_decim_ctrl #(
    parameter int RATE_W   = 8,
    parameter int COMB_D   = 3,
    parameter int COMB_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    cic_decim_ctrl_if.slave  bus
);
    localparam int WARM_W = (COMB_D < 1) ? 1 : $clog2(COMB_D + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [RATE_W-1:0]   phase_r;
    logic [RATE_W-1:0]   phase_next_s;
    logic [RATE_W-1:0]   rate_r;
    logic [WARM_W-1:0]   warm_r;
    logic [COMB_LAT-1:0] vpipe_r;
    logic                comb_en_r;
    logic                int_clr_r;
    logic                comb_clr_r;
    logic                in_ready_r;
    logic                busy_r;
    logic                accept_s;
    logic                fire_s;
    logic                inflight_s;
    logic                warm_ok_s;

    assign accept_s   = bus.in_valid_i & in_ready_r;
    assign fire_s     = accept_s & (phase_r == (rate_r - RATE_W'(1)));
    assign inflight_s = comb_en_r | (|vpipe_r);
    assign warm_ok_s  = (warm_r >= WARM_W'(COMB_D));

    // Next-state and phase counter decode.
    always_comb begin
        state_next_s = state_r;
        phase_next_s = phase_r;
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    state_next_s = CLEAR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CLEAR: begin
                phase_next_s = {RATE_W{1'b0}};
                state_next_s = RUN;
            end
            RUN: begin
                if (fire_s) begin
                    phase_next_s = {RATE_W{1'b0}};
                end else if (accept_s) begin
                    phase_next_s = phase_r + RATE_W'(1);
                end else begin
                    phase_next_s = phase_r;
                end
                // With nothing in flight there is no point lingering in DRAIN.
                if (bus.stop_i) begin
                    phase_next_s = {RATE_W{1'b0}};
                    state_next_s = (fire_s | inflight_s) ? DRAIN : IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                phase_next_s = {RATE_W{1'b0}};
                if (!inflight_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                phase_next_s = {RATE_W{1'b0}};
                state_next_s = IDLE;
            end
        endcase
    end

    // State, rate latch, warm-up counter and registered control outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r    <= IDLE;
            phase_r    <= {RATE_W{1'b0}};
            rate_r     <= RATE_W'(1);
            warm_r     <= {WARM_W{1'b0}};
            comb_en_r  <= 1'b0;
            vpipe_r    <= {COMB_LAT{1'b0}};
            int_clr_r  <= 1'b0;
            comb_clr_r <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r <= state_next_s;
            phase_r <= phase_next_s;
            if ((state_r == IDLE) && bus.start_i) begin
                rate_r <= (bus.cfg_rate_i == {RATE_W{1'b0}}) ? RATE_W'(1) : bus.cfg_rate_i;
            end
            if (state_r == CLEAR) begin
                warm_r <= {WARM_W{1'b0}};
            end else if (comb_en_r && !warm_ok_s) begin
                warm_r <= warm_r + WARM_W'(1);
            end
            comb_en_r  <= fire_s;
            // Masked warm-up strobes enter the pipe as zeros.
            vpipe_r[0] <= comb_en_r & warm_ok_s;
            for (int i = 1; i < COMB_LAT; i++) begin
                vpipe_r[i] <= vpipe_r[i-1];
            end
            int_clr_r  <= (state_next_s == CLEAR);
            comb_clr_r <= (state_next_s == CLEAR);
            in_ready_r <= (state_next_s == RUN);
            busy_r     <= (state_next_s != IDLE);
        end
    end

    assign bus.in_ready_o  = in_ready_r;
    assign bus.int_en_o    = accept_s;
    assign bus.int_clr_o   = int_clr_r;
    assign bus.comb_en_o   = comb_en_r;
    assign bus.comb_clr_o  = comb_clr_r;
    assign bus.out_valid_o = vpipe_r[COMB_LAT-1];
    assign bus.busy_o      = busy_r;
    assign bus.state_o     = state_r;
    assign bus.phase_o     = phase_r;
endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Scoreboard bench for cic_decim_ctrl: stimulus pushes expected strobe/valid
// cycles into queues, a negedge monitor pops and compares them.
module tb_cic_decim_ctrl;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cic_decim_ctrl_if #(.RATE_W(8)) bus ();

    cic_decim_ctrl #(.RATE_W(8), .COMB_D(3), .COMB_LAT(1)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int sq[$];
    int oq[$];
    int strobes_seen = 0;
    bit m_run = 1'b0;
    int m_rate = 1;
    int m_acc = 0;
    int m_nstrobe = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every strobe / output valid against the scoreboard queues.
    always @(negedge clk) begin
        int e;
        if (sq.size() > 0 && sq[0] < cyc) begin
            tests++; fails++;
            e = sq.pop_front();
            $display("FAIL comb_en_missed: got none expected strobe at cycle %0d", e);
        end
        if (oq.size() > 0 && oq[0] < cyc) begin
            tests++; fails++;
            e = oq.pop_front();
            $display("FAIL out_valid_missed: got none expected valid at cycle %0d", e);
        end
        if (bus.comb_en_o === 1'b1) begin
            strobes_seen++;
            tests++;
            if (sq.size() == 0) begin
                fails++;
                $display("FAIL comb_en_unexpected: got strobe at cycle %0d expected none", cyc);
            end else begin
                e = sq.pop_front();
                if (e != cyc) begin
                    fails++;
                    $display("FAIL comb_en_time: got cycle %0d expected cycle %0d", cyc, e);
                end
            end
        end
        if (bus.out_valid_o === 1'b1) begin
            tests++;
            if (oq.size() == 0) begin
                fails++;
                $display("FAIL out_valid_unexpected: got valid at cycle %0d expected none", cyc);
            end else begin
                e = oq.pop_front();
                if (e != cyc) begin
                    fails++;
                    $display("FAIL out_valid_time: got cycle %0d expected cycle %0d", cyc, e);
                end
            end
        end
    end

    // One stimulus cycle; pushes the expected strobe/valid cycles for an accept.
    task automatic drive(input bit v, input bit s);
        int  n;
        bit  acc_now;
        n = cyc;
        bus.in_valid_i = v;
        bus.stop_i     = s;
        acc_now = m_run && v;
        #1;
        check("int_en", 32'(bus.int_en_o), 32'(acc_now));
        if (acc_now) begin
            m_acc++;
            if (m_acc == m_rate) begin
                m_acc = 0;
                sq.push_back(n + 1);
                if (m_nstrobe >= 3) oq.push_back(n + 2);
                m_nstrobe++;
            end
        end
        if (s && m_run) begin
            m_run = 1'b0;
            m_acc = 0;
        end
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        bus.stop_i     = 1'b0;
        check("phase", 32'(bus.phase_o), 32'(m_acc));
        check("in_ready", 32'(bus.in_ready_o), 32'(m_run));
    endtask

    task automatic start_run(input int rate);
        bus.cfg_rate_i = 8'(rate);
        bus.start_i    = 1'b1;
        @(posedge clk); #1;
        bus.start_i    = 1'b0;
        bus.cfg_rate_i = 8'd7;
        check("clear_state", 32'(bus.state_o), 32'd1);
        check("int_clr", 32'(bus.int_clr_o), 32'd1);
        check("comb_clr", 32'(bus.comb_clr_o), 32'd1);
        check("clear_ready", 32'(bus.in_ready_o), 32'd0);
        check("clear_busy", 32'(bus.busy_o), 32'd1);
        @(posedge clk); #1;
        check("run_state", 32'(bus.state_o), 32'd2);
        check("int_clr_end", 32'(bus.int_clr_o), 32'd0);
        check("comb_clr_end", 32'(bus.comb_clr_o), 32'd0);
        check("run_ready", 32'(bus.in_ready_o), 32'd1);
        m_run     = 1'b1;
        m_rate    = (rate == 0) ? 1 : rate;
        m_acc     = 0;
        m_nstrobe = 0;
    endtask

    task automatic stop_idle();
        repeat (3) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        check("stop_state", 32'(bus.state_o), 32'd0);
        check("stop_busy", 32'(bus.busy_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(bus.state_o), 32'd0);
        check({tag, "_ready"}, 32'(bus.in_ready_o), 32'd0);
        check({tag, "_int_clr"}, 32'(bus.int_clr_o), 32'd0);
        check({tag, "_comb_en"}, 32'(bus.comb_en_o), 32'd0);
        check({tag, "_comb_clr"}, 32'(bus.comb_clr_o), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, "_phase"}, 32'(bus.phase_o), 32'd0);
    endtask

    initial begin
        bus.cfg_rate_i = 8'd0;
        bus.start_i    = 1'b0;
        bus.stop_i     = 1'b0;
        bus.in_valid_i = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("reset");
        bus.in_valid_i = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", 32'(bus.state_o), 32'd0);

        // R=4, continuous input: 6 strobes, first 3 masked.
        start_run(4);
        strobes_seen = 0;
        repeat (24) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("r4_strobe_count", 32'(strobes_seen), 32'd6);
        stop_idle();

        // R=4, toggling input, then stop at phase 2 with nothing in flight.
        start_run(4);
        for (int i = 0; i < 16; i++) drive((i % 2) == 0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        check("phase_before_stop", 32'(bus.phase_o), 32'd2);
        drive(1'b0, 1'b1);
        check("stop_p2_state", 32'(bus.state_o), 32'd0);
        check("stop_p2_phase", 32'(bus.phase_o), 32'd0);
        drive(1'b1, 1'b0);

        // cfg_rate_i=0 behaves as R=1: back-to-back strobes.
        start_run(0);
        strobes_seen = 0;
        repeat (10) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        check("r1_strobe_count", 32'(strobes_seen), 32'd10);
        stop_idle();

        // Stop coincident with the completing accept of a warm strobe.
        start_run(4);
        repeat (15) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        check("drain_state", 32'(bus.state_o), 32'd3);
        check("drain_comb_en", 32'(bus.comb_en_o), 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (bus.state_o == 2'd0) break;
            drive(1'b1, 1'b0);
        end
        check("drain_to_idle", 32'(bus.state_o), 32'd0);
        check("drain_phase", 32'(bus.phase_o), 32'd0);

        // Reset mid-RUN with a strobe pending, then a clean restart.
        start_run(1);
        drive(1'b1, 1'b0);
        check("pending_strobe", 32'(bus.comb_en_o), 32'd1);
        rstn = 1'b0;
        sq.delete();
        oq.delete();
        m_run = 1'b0;
        m_acc = 0;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        start_run(2);
        repeat (4) drive(1'b1, 1'b0);
        stop_idle();

        check("scoreboard_strobes_left", 32'(sq.size()), 32'd0);
        check("scoreboard_valids_left", 32'(oq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/cic_decim_ctrl.md
Name: cic_decim_ctrl

Overview:
- Sequencer for the single-stage CIC datapath (integrator → comb, comb delay D=3) used as a decimator.
- Gates integrator enable per accepted input sample and fires the comb enable once every R accepted samples, aligned to the integrator's 1-cycle output register.
- Clears filter state on start, masks comb warm-up outputs and drains the pipeline on stop.
- Sits between the sample source and the integrator/comb instances; owns no datapath arithmetic.

Parameters:
- RATE_W, 8, width of decimation-rate config.
- COMB_D, 3, comb differential delay; number of leading decimated outputs masked as transient.
- COMB_LAT, 1, cycles from comb_en_o to comb output valid.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_rate_i  in  RATE_W  decimation rate R; sampled only on start; 0 treated as 1
- start_i  in  1  start request (pulse)
- stop_i  in  1  stop request (pulse)
- in_valid_i  in  1  input sample valid
- in_ready_o  out  1  controller accepts samples (RUN only)
- int_en_o  out  1  integrator enable = in_valid_i & in_ready_o (combinational)
- int_clr_o  out  1  integrator state clear
- comb_en_o  out  1  comb enable strobe (registered)
- comb_clr_o  out  1  comb delay-line clear
- out_valid_o  out  1  decimated output valid at comb data_o
- busy_o  out  1  state != IDLE
- state_o  out  2  IDLE=0, CLEAR=1, RUN=2, DRAIN=3
- phase_o  out  RATE_W  current decimation phase counter

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low; all flops are reset by rstn_i.
- Reset values: state IDLE. in_ready_o, int_clr_o, comb_en_o, comb_clr_o, out_valid_o and busy_o all 0. phase_o=0. Latched rate=1. Warm-up counter=0. Valid pipe=0.
- Accept: a sample is accepted in a cycle with in_valid_i=1 and in_ready_o=1.
- FSM:
  - IDLE: in_ready_o=0. On start_i, latch R=max(cfg_rate_i,1) and go to CLEAR. stop_i is ignored.
  - CLEAR: exactly 1 cycle. int_clr_o=comb_clr_o=1. phase cleared to 0, warm-up counter cleared to 0. Go to RUN.
  - RUN: in_ready_o=1.
    - On accept: if phase==R-1, phase wraps to 0 and comb_en_o=1 next cycle; else phase+1.
    - stop_i in RUN goes to DRAIN. A sample accepted in the same cycle is still counted and may still fire comb_en_o.
    - start_i in RUN is ignored.
  - DRAIN: in_ready_o=0; no new int_en_o. Any partial phase is discarded. Stay until comb_en_o and the COMB_LAT valid pipe are empty, then go to IDLE (phase reset to 0).
- Latency:
  - comb_en_o rises exactly 1 cycle after the accept that completes a phase.
  - out_valid_o = comb_en_o delayed COMB_LAT cycles, suppressed while warm-up count < COMB_D.
  - Warm-up counter increments per comb_en_o and saturates at COMB_D.
- R=1: comb_en_o follows every accept with 1-cycle delay; back-to-back strobes are legal.
- cfg_rate_i changes outside start have no effect until the next start.
- Reset asserted mid-RUN: immediate return to reset values. Pending comb_en_o and out_valid_o are lost.

Test Plan:
- Reset, then start with cfg_rate_i=4 and in_valid_i held 1 for 24 cycles → 1-cycle int_clr_o/comb_clr_o pulse; comb_en_o on the cycle after the 4th, 8th, …, 24th accept (6 strobes); out_valid_o masked for first 3 strobes, asserted COMB_LAT=1 cycle after strobes 4, 5, 6.
- R=4 with in_valid_i toggling 1/0 → strobe only after every 4th accepted sample; phase_o holds during idle input cycles.
- cfg_rate_i=0 → treated as R=1: 10 accepts give 10 back-to-back comb_en_o pulses, the first 3 masked.
- stop_i asserted with phase_o=2 (R=4), no in-flight strobe → DRAIN for 0 cycles, IDLE next cycle; no comb_en_o; phase_o=0.
- stop_i in the same cycle as the 4th accept → sample accepted, comb_en_o next cycle, out_valid_o one cycle later (if warm), then IDLE; in_ready_o=0 from the cycle after stop.
- rstn_i low for 1 cycle mid-RUN with a strobe pending → all outputs 0 immediately, state_o=0; a subsequent start restarts from a clean CLEAR.
